// File: rtl/cam_pkg.sv
// ---------------------------------------------------------------------------
// cam_pkg
// Shared types and defaults for the CAM learning controller.
//   CAM_DATA_WIDTH / CAM_ADDR_WIDTH : default key and index widths
//   cam_learn_state_t               : controller FSM states
//   cam_rsp_t                       : registered response fields
// ---------------------------------------------------------------------------
package cam_pkg;

   localparam int CAM_DATA_WIDTH = 32;
   localparam int CAM_ADDR_WIDTH = 5;

   typedef enum logic [2:0] {
      IDLE,
      SEARCH,
      WAIT,
      WRITE,
      RESP
   } cam_learn_state_t;

   // "new" is a reserved word, hence is_new.
   typedef struct packed {
      logic                      hit;
      logic                      is_new;
      logic                      evict;
      logic [CAM_ADDR_WIDTH-1:0] index;
   } cam_rsp_t;

   localparam cam_rsp_t CAM_RSP_NONE = '0;

endpackage

// File: rtl/cam_alloc.sv
// ---------------------------------------------------------------------------
// cam_alloc
// Entry allocator for the CAM learning controller. Hands out free entries in
// order while the CAM is filling, then round-robin victims once it is full.
//   clk, rst      : clock, asynchronous active-high reset
//   alloc_i       : consume next_index_o this cycle
//   next_index_o  : index the next write should use
//   full_o        : every entry has been learned; next write evicts
//   fill_o        : number of entries learned, saturates at DEPTH
// ---------------------------------------------------------------------------
module cam_alloc #(
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alloc_i,
   output logic [ADDR_WIDTH-1:0] next_index_o,
   output logic                  full_o,
   output logic [ADDR_WIDTH:0]   fill_o
);

   localparam logic [ADDR_WIDTH:0]   FILL_MAX   = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(DEPTH - 1);

   logic [ADDR_WIDTH:0]   fill_q;
   logic [ADDR_WIDTH-1:0] victim_q;

   assign full_o       = (fill_q == FILL_MAX);
   assign fill_o       = fill_q;
   assign next_index_o = full_o ? victim_q : fill_q[ADDR_WIDTH-1:0];

   // The fill count and the victim pointer never move together: the pointer
   // only starts rotating after the fill count has saturated. The explicit
   // wrap keeps the rotation correct for non-power-of-two depths.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_q   <= '0;
         victim_q <= '0;
      end else if (alloc_i) begin
         if (!full_o) begin
            fill_q <= fill_q + 1'b1;
         end else if (victim_q == LAST_INDEX) begin
            victim_q <= '0;
         end else begin
            victim_q <= victim_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/cam_learn_ctrl.sv
// ---------------------------------------------------------------------------
// cam_learn_ctrl
// Upstream controller for the CAM. Takes one key lookup at a time, searches
// the CAM, and on a miss with learning enabled writes the key into a free or
// victim entry before responding.
//   clk, rst            : clock, asynchronous active-high reset
//   req_*               : valid/ready request channel (key + learn enable)
//   rsp_*               : valid/ready response channel (hit/new/evict/index)
//   cam_search_*        : search strobe and key; hit result one cycle later
//   cam_write_*         : write strobe, index and key
//   occupancy_o         : entries learned so far, 0..DEPTH
// Response index width follows cam_pkg::CAM_ADDR_WIDTH; instantiate with a
// matching ADDR_WIDTH.
// ---------------------------------------------------------------------------
module cam_learn_ctrl
   import cam_pkg::*;
#(
   parameter int DATA_WIDTH = CAM_DATA_WIDTH,
   parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
   parameter int DEPTH      = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [DATA_WIDTH-1:0] req_key_i,
   input  logic                  learn_en_i,

   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic                  rsp_hit_o,
   output logic                  rsp_new_o,
   output logic                  rsp_evict_o,
   output logic [ADDR_WIDTH-1:0] rsp_index_o,

   output logic                  cam_search_o,
   output logic [DATA_WIDTH-1:0] cam_search_data_o,
   input  logic                  cam_search_valid_i,
   input  logic [ADDR_WIDTH-1:0] cam_search_index_i,

   output logic                  cam_write_o,
   output logic [ADDR_WIDTH-1:0] cam_write_index_o,
   output logic [DATA_WIDTH-1:0] cam_write_data_o,

   output logic [ADDR_WIDTH:0]   occupancy_o
);

   cam_learn_state_t      state_q, state_d;
   logic [DATA_WIDTH-1:0] key_q;
   logic                  learn_q;
   cam_rsp_t              rsp_q;

   logic                  alloc;
   logic [ADDR_WIDTH-1:0] alloc_index;
   logic                  alloc_full;

   cam_alloc #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_alloc (
      .clk          (clk),
      .rst          (rst),
      .alloc_i      (alloc),
      .next_index_o (alloc_index),
      .full_o       (alloc_full),
      .fill_o       (occupancy_o)
   );

   // Strobes decode straight from the state register so an asynchronous
   // reset kills a search or write strobe in the same cycle.
   assign req_ready_o       = (state_q == IDLE);
   assign cam_search_o      = (state_q == SEARCH);
   assign cam_write_o       = (state_q == WRITE);
   assign alloc             = cam_write_o;
   assign cam_write_index_o = alloc_index;
   assign cam_search_data_o = key_q;
   assign cam_write_data_o  = key_q;

   assign rsp_valid_o = (state_q == RESP);
   assign rsp_hit_o   = rsp_q.hit;
   assign rsp_new_o   = rsp_q.is_new;
   assign rsp_evict_o = rsp_q.evict;
   assign rsp_index_o = ADDR_WIDTH'(rsp_q.index);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // WAIT is the cycle in which the CAM presents the result of the search
   // strobed in SEARCH; a miss branches to WRITE only when learning was
   // requested with this key.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid_i) state_d = SEARCH;
         SEARCH:  state_d = WAIT;
         WAIT: begin
            if (cam_search_valid_i)  state_d = RESP;
            else if (learn_q)        state_d = WRITE;
            else                     state_d = RESP;
         end
         WRITE:   state_d = RESP;
         RESP:    if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request capture and response registration. The response is built in
   // WAIT (hit or plain miss) or in WRITE (learned miss) and then held
   // untouched through RESP, so a stalled consumer sees stable fields.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_q   <= '0;
         learn_q <= 1'b0;
         rsp_q   <= CAM_RSP_NONE;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  key_q   <= req_key_i;
                  learn_q <= learn_en_i;
               end
            end
            WAIT: begin
               if (cam_search_valid_i) begin
                  rsp_q.hit    <= 1'b1;
                  rsp_q.is_new <= 1'b0;
                  rsp_q.evict  <= 1'b0;
                  rsp_q.index  <= CAM_ADDR_WIDTH'(cam_search_index_i);
               end else if (!learn_q) begin
                  rsp_q <= CAM_RSP_NONE;
               end
            end
            WRITE: begin
               rsp_q.hit    <= 1'b0;
               rsp_q.is_new <= 1'b1;
               rsp_q.evict  <= alloc_full;
               rsp_q.index  <= CAM_ADDR_WIDTH'(alloc_index);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cam_learn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cam_learn_ctrl
// Directed bench for cam_learn_ctrl with a behavioural 32-entry CAM attached.
// Latency is the number of rising edges from the accept edge (counted as 1)
// up to and including the edge after which rsp_valid_o is seen high.
// ---------------------------------------------------------------------------
module tb_cam_learn_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [31:0] req_key_i = '0;
   logic        learn_en_i = 1'b0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic        rsp_hit_o;
   logic        rsp_new_o;
   logic        rsp_evict_o;
   logic [4:0]  rsp_index_o;
   logic        cam_search_o;
   logic [31:0] cam_search_data_o;
   logic        cam_search_valid_i = 1'b0;
   logic [4:0]  cam_search_index_i = '0;
   logic        cam_write_o;
   logic [4:0]  cam_write_index_o;
   logic [31:0] cam_write_data_o;
   logic [5:0]  occupancy_o;

   int total = 0;
   int bad   = 0;

   // Behavioural CAM state and write monitor
   logic [31:0] cam_mem [32];
   logic        cam_vld [32];
   logic        srch_found;
   logic [4:0]  srch_idx;
   int          wr_count = 0;
   logic [4:0]  last_wr_idx = '0;

   always #5 clk = ~clk;

   cam_learn_ctrl dut (
      .clk                (clk),
      .rst                (rst),
      .req_valid_i        (req_valid_i),
      .req_ready_o        (req_ready_o),
      .req_key_i          (req_key_i),
      .learn_en_i         (learn_en_i),
      .rsp_valid_o        (rsp_valid_o),
      .rsp_ready_i        (rsp_ready_i),
      .rsp_hit_o          (rsp_hit_o),
      .rsp_new_o          (rsp_new_o),
      .rsp_evict_o        (rsp_evict_o),
      .rsp_index_o        (rsp_index_o),
      .cam_search_o       (cam_search_o),
      .cam_search_data_o  (cam_search_data_o),
      .cam_search_valid_i (cam_search_valid_i),
      .cam_search_index_i (cam_search_index_i),
      .cam_write_o        (cam_write_o),
      .cam_write_index_o  (cam_write_index_o),
      .cam_write_data_o   (cam_write_data_o),
      .occupancy_o        (occupancy_o)
   );

   // The CAM answers a search one cycle after the strobe; contents survive
   // controller reset, as a real CAM would.
   always @(posedge clk) begin
      if (cam_write_o) begin
         cam_mem[cam_write_index_o] = cam_write_data_o;
         cam_vld[cam_write_index_o] = 1'b1;
         wr_count++;
         last_wr_idx = cam_write_index_o;
      end
      if (cam_search_o) begin
         srch_found = 1'b0;
         srch_idx   = '0;
         for (int i = 0; i < 32; i++) begin
            if (!srch_found && cam_vld[i] && cam_mem[i] == cam_search_data_o) begin
               srch_found = 1'b1;
               srch_idx   = 5'(i);
            end
         end
         cam_search_valid_i <= srch_found;
         cam_search_index_i <= srch_idx;
      end else begin
         cam_search_valid_i <= 1'b0;
      end
      if (cam_search_o && cam_write_o) begin
         bad++;
         $display("[TB] FAIL strobe_overlap: search=%0b write=%0b required not both", cam_search_o, cam_write_o);
      end
   end

   // Drives one request, waits for the response and completes its handshake.
   task automatic run_req(input logic [31:0] key, input logic learn,
                          output int lat, output logic hit, output logic nw,
                          output logic ev, output logic [4:0] idx, output logic to);
      int n;
      to = 1'b0; lat = 0; hit = 1'b0; nw = 1'b0; ev = 1'b0; idx = '0;
      @(negedge clk);
      n = 0;
      while (!req_ready_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready_o) begin
         to = 1'b1;
         return;
      end
      req_valid_i = 1'b1;
      req_key_i   = key;
      learn_en_i  = learn;
      @(posedge clk);
      lat = 1;
      #1 req_valid_i = 1'b0;
      learn_en_i = 1'b0;
      @(negedge clk);
      while (!rsp_valid_o && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (!rsp_valid_o) begin
         to = 1'b1;
         return;
      end
      hit = rsp_hit_o; nw = rsp_new_o; ev = rsp_evict_o; idx = rsp_index_o;
      rsp_ready_i = 1'b1;
      @(posedge clk);
      #1 rsp_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++; if (req_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready: got %b want 1", req_ready_o); end
      total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_rsp_valid: got %b want 0", rsp_valid_o); end
      total++; if ({cam_search_o, cam_write_o} !== 2'b00) begin bad++; $display("[TB] FAIL rst_strobes: got %b want 00", {cam_search_o, cam_write_o}); end
      total++; if (occupancy_o !== 6'd0) begin bad++; $display("[TB] FAIL rst_occ: got %0d want 0", occupancy_o); end
      total++; if ({rsp_hit_o, rsp_new_o, rsp_evict_o, rsp_index_o} !== 8'h00) begin bad++; $display("[TB] FAIL rst_rsp_fields: got %h want 00", {rsp_hit_o, rsp_new_o, rsp_evict_o, rsp_index_o}); end
      total++; if (cam_search_data_o !== 32'h0) begin bad++; $display("[TB] FAIL rst_key: got %h want 0", cam_search_data_o); end
      rst = 1'b0;
      @(negedge clk);
      total++; if (req_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL post_rst_ready: got %b want 1", req_ready_o); end
   endtask

   task automatic test_learn_first();
      int lat; logic hit, nw, ev, to; logic [4:0] idx; int wc;
      wc = wr_count;
      run_req(32'hDEADBEEF, 1'b1, lat, hit, nw, ev, idx, to);
      total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL learn_first_timeout: got %b want 0", to); end
      total++; if (lat !== 4) begin bad++; $display("[TB] FAIL learn_first_latency: got %0d want 4", lat); end
      total++; if ({hit, nw, ev, idx} !== {3'b010, 5'd0}) begin bad++; $display("[TB] FAIL learn_first_rsp: got h%b n%b e%b i%0d want h0 n1 e0 i0", hit, nw, ev, idx); end
      total++; if (wr_count - wc !== 1 || last_wr_idx !== 5'd0) begin bad++; $display("[TB] FAIL learn_first_write: got %0d writes idx %0d want 1 idx 0", wr_count - wc, last_wr_idx); end
      total++; if (occupancy_o !== 6'd1) begin bad++; $display("[TB] FAIL learn_first_occ: got %0d want 1", occupancy_o); end
   endtask

   task automatic test_hit();
      int lat; logic hit, nw, ev, to; logic [4:0] idx; int wc;
      wc = wr_count;
      run_req(32'hDEADBEEF, 1'b1, lat, hit, nw, ev, idx, to);
      total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL hit_timeout: got %b want 0", to); end
      total++; if (lat !== 3) begin bad++; $display("[TB] FAIL hit_latency: got %0d want 3", lat); end
      total++; if ({hit, nw, ev, idx} !== {3'b100, 5'd0}) begin bad++; $display("[TB] FAIL hit_rsp: got h%b n%b e%b i%0d want h1 n0 e0 i0", hit, nw, ev, idx); end
      total++; if (wr_count !== wc) begin bad++; $display("[TB] FAIL hit_no_write: got %0d writes want 0", wr_count - wc); end
      total++; if (occupancy_o !== 6'd1) begin bad++; $display("[TB] FAIL hit_occ: got %0d want 1", occupancy_o); end
   endtask

   task automatic test_nolearn_miss();
      int lat; logic hit, nw, ev, to; logic [4:0] idx; int wc;
      wc = wr_count;
      run_req(32'h12345678, 1'b0, lat, hit, nw, ev, idx, to);
      total++; if (to !== 1'b0 || lat !== 3) begin bad++; $display("[TB] FAIL nolearn_latency: got %0d to=%b want 3", lat, to); end
      total++; if ({hit, nw, ev, idx} !== 8'h00) begin bad++; $display("[TB] FAIL nolearn_rsp: got h%b n%b e%b i%0d want all 0", hit, nw, ev, idx); end
      total++; if (wr_count !== wc) begin bad++; $display("[TB] FAIL nolearn_no_write: got %0d writes want 0", wr_count - wc); end
      total++; if (occupancy_o !== 6'd1) begin bad++; $display("[TB] FAIL nolearn_occ: got %0d want 1", occupancy_o); end
   endtask

   task automatic test_fill_and_evict();
      int lat; logic hit, nw, ev, to; logic [4:0] idx;
      for (int i = 1; i < 32; i++) begin
         run_req(32'h1000 + i, 1'b1, lat, hit, nw, ev, idx, to);
         total++;
         if (to !== 1'b0 || lat !== 4 || {hit, nw, ev} !== 3'b010 || idx !== 5'(i)) begin
            bad++; $display("[TB] FAIL fill_%0d: got lat%0d h%b n%b e%b i%0d want lat4 h0 n1 e0 i%0d", i, lat, hit, nw, ev, idx, i);
         end
      end
      total++; if (occupancy_o !== 6'd32) begin bad++; $display("[TB] FAIL fill_occ: got %0d want 32", occupancy_o); end
      for (int j = 0; j < 4; j++) begin
         run_req(32'h2000 + j, 1'b1, lat, hit, nw, ev, idx, to);
         total++;
         if (to !== 1'b0 || {hit, nw, ev} !== 3'b011 || idx !== 5'(j) || last_wr_idx !== 5'(j)) begin
            bad++; $display("[TB] FAIL evict_%0d: got h%b n%b e%b i%0d wr%0d want h0 n1 e1 i%0d", j, hit, nw, ev, idx, last_wr_idx, j);
         end
         total++; if (occupancy_o !== 6'd32) begin bad++; $display("[TB] FAIL evict_occ_%0d: got %0d want 32", j, occupancy_o); end
      end
      run_req(32'h2001, 1'b0, lat, hit, nw, ev, idx, to);
      total++; if ({hit, nw, idx} !== {2'b10, 5'd1}) begin bad++; $display("[TB] FAIL evicted_key_hit: got h%b n%b i%0d want h1 n0 i1", hit, nw, idx); end
   endtask

   task automatic test_resp_stall();
      int lat;
      @(negedge clk);
      total++; if (req_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL stall_ready_start: got %b want 1", req_ready_o); end
      req_valid_i = 1'b1; req_key_i = 32'h2002; learn_en_i = 1'b0;
      @(posedge clk);
      lat = 1;
      #1 req_key_i = 32'hAAAA5555;
      @(negedge clk);
      while (!rsp_valid_o && lat < 20) begin
         @(posedge clk); lat++; @(negedge clk);
      end
      total++; if (lat !== 3) begin bad++; $display("[TB] FAIL stall_first_latency: got %0d want 3", lat); end
      for (int k = 0; k < 5; k++) begin
         total++;
         if (rsp_valid_o !== 1'b1 || rsp_hit_o !== 1'b1 || rsp_new_o !== 1'b0 || rsp_index_o !== 5'd2 || req_ready_o !== 1'b0) begin
            bad++; $display("[TB] FAIL stall_hold_%0d: got v%b h%b n%b i%0d rdy%b want v1 h1 n0 i2 rdy0", k, rsp_valid_o, rsp_hit_o, rsp_new_o, rsp_index_o, req_ready_o);
         end
         @(negedge clk);
      end
      rsp_ready_i = 1'b1;
      @(posedge clk);
      #1 rsp_ready_i = 1'b0;
      @(negedge clk);
      total++; if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL stall_release: got rdy%b v%b want rdy1 v0", req_ready_o, rsp_valid_o); end
      @(posedge clk);
      lat = 1;
      #1 req_valid_i = 1'b0;
      @(negedge clk);
      while (!rsp_valid_o && lat < 20) begin
         @(posedge clk); lat++; @(negedge clk);
      end
      total++; if (lat !== 3 || {rsp_hit_o, rsp_new_o, rsp_index_o} !== 7'd0) begin bad++; $display("[TB] FAIL stall_second_rsp: got lat%0d h%b n%b i%0d want lat3 h0 n0 i0", lat, rsp_hit_o, rsp_new_o, rsp_index_o); end
      rsp_ready_i = 1'b1;
      @(posedge clk);
      #1 rsp_ready_i = 1'b0;
   endtask

   task automatic test_reset_during_write();
      int lat, n, wc; logic hit, nw, ev, to; logic [4:0] idx;
      @(negedge clk);
      req_valid_i = 1'b1; req_key_i = 32'h3000; learn_en_i = 1'b1;
      @(posedge clk);
      #1 req_valid_i = 1'b0; learn_en_i = 1'b0;
      n = 0;
      @(negedge clk);
      while (!cam_write_o && n < 10) begin
         @(negedge clk); n++;
      end
      total++; if (cam_write_o !== 1'b1 || cam_write_index_o !== 5'd4) begin bad++; $display("[TB] FAIL rstw_reach_write: got w%b i%0d want w1 i4", cam_write_o, cam_write_index_o); end
      wc = wr_count;
      rst = 1'b1;
      #1;
      total++; if (cam_write_o !== 1'b0) begin bad++; $display("[TB] FAIL rstw_write_cut: got %b want 0", cam_write_o); end
      total++; if (occupancy_o !== 6'd0 || req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL rstw_state: got occ%0d rdy%b v%b want occ0 rdy1 v0", occupancy_o, req_ready_o, rsp_valid_o); end
      @(negedge clk);
      rst = 1'b0;
      total++; if (wr_count !== wc) begin bad++; $display("[TB] FAIL rstw_no_commit: got %0d writes want 0", wr_count - wc); end
      run_req(32'h4000, 1'b1, lat, hit, nw, ev, idx, to);
      total++; if (to !== 1'b0 || lat !== 4 || {hit, nw, ev, idx} !== {3'b010, 5'd0}) begin bad++; $display("[TB] FAIL rstw_relearn: got lat%0d h%b n%b e%b i%0d want lat4 h0 n1 e0 i0", lat, hit, nw, ev, idx); end
      total++; if (occupancy_o !== 6'd1) begin bad++; $display("[TB] FAIL rstw_occ: got %0d want 1", occupancy_o); end
      run_req(32'h1005, 1'b0, lat, hit, nw, ev, idx, to);
      total++; if ({hit, nw, idx} !== {2'b10, 5'd5}) begin bad++; $display("[TB] FAIL rstw_contents_kept: got h%b n%b i%0d want h1 n0 i5", hit, nw, idx); end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         cam_mem[i] = '0;
         cam_vld[i] = 1'b0;
      end
      test_reset();
      test_learn_first();
      test_hit();
      test_nolearn_miss();
      test_fill_and_evict();
      test_resp_stall();
      test_reset_during_write();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
